// File: rtl/jtcop_bank_arb.sv
// Round-robin arbiter: four SDRAM bank ports onto one single-port memory command interface.
// Optional macro JTCOP_ARB_PRIO0_EN gives bank 0 absolute priority over the round-robin.
module jtcop_bank_arb #(
   parameter int AW    = 22,
   parameter int BURST = 2
)(
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] ba0_addr,
   input  logic [AW-1:0] ba1_addr,
   input  logic [AW-1:0] ba2_addr,
   input  logic [AW-1:0] ba3_addr,
   input  logic [3:0]    ba_rd,
   input  logic          ba_wr,
   input  logic [15:0]   ba0_din,
   input  logic [1:0]    ba0_din_m,
   output logic [3:0]    ba_ack,
   output logic [3:0]    ba_dst,
   output logic [3:0]    ba_dok,
   output logic [3:0]    ba_rdy,
   output logic [15:0]   data_read,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [15:0]   mem_din,
   output logic [1:0]    mem_mask,
   input  logic          mem_gnt,
   input  logic          mem_vld,
   input  logic [15:0]   mem_dout
);

   typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

   localparam logic [1:0] LAST = 2'(BURST - 1);

   state_t        st;
   logic [1:0]    ptr;
   logic [1:0]    win;
   logic [1:0]    cnt;
   logic [3:0]    req;
   logic [3:0]    req_rr;
   logic [1:0]    pick;
   logic          wr_sel;
   logic [AW-1:0] addr_sel;

   always_comb begin
      req    = {ba_rd[3:1], ba_rd[0] | ba_wr};
      req_rr = req;
`ifdef JTCOP_ARB_PRIO0_EN
      req_rr[0] = 1'b0;
`endif
   end

   // Scan from the farthest slot back to ptr so the last hit is the first in rotation order
   always_comb begin
      logic [1:0] idx;
      idx  = '0;
      pick = ptr;
      for (int unsigned k = 0; k < 4; k++) begin
         idx = ptr + 2'(3 - k);
         if (req_rr[idx]) pick = idx;
      end
`ifdef JTCOP_ARB_PRIO0_EN
      if (req[0]) pick = 2'd0;
`endif
   end

   always_comb begin
      wr_sel = (pick == 2'd0) && ba_wr;
      case (pick)
         2'd0:    addr_sel = ba0_addr;
         2'd1:    addr_sel = ba1_addr;
         2'd2:    addr_sel = ba2_addr;
         default: addr_sel = ba3_addr;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st        <= IDLE;
         ptr       <= '0;
         win       <= '0;
         cnt       <= '0;
         ba_ack    <= '0;
         ba_dst    <= '0;
         ba_dok    <= '0;
         ba_rdy    <= '0;
         data_read <= '0;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_din   <= '0;
         mem_mask  <= '0;
      end else begin
         ba_ack <= '0;
         ba_dst <= '0;
         ba_dok <= '0;
         ba_rdy <= '0;
         case (st)
            IDLE: begin
               if (|req) begin
                  win      <= pick;
                  mem_addr <= addr_sel;
                  mem_we   <= wr_sel;
                  if (wr_sel) begin
                     mem_din  <= ba0_din;
                     mem_mask <= ba0_din_m;
                  end
                  mem_req  <= 1'b1;
                  st       <= CMD;
               end
            end
            CMD: begin
               if (mem_gnt) begin
                  mem_req     <= 1'b0;
                  ba_ack[win] <= 1'b1;
                  cnt         <= '0;
                  st          <= DATA;
               end
            end
            DATA: begin
               if (mem_vld) begin
                  ba_dok[win] <= 1'b1;
                  if (cnt == 2'd0) ba_dst[win] <= 1'b1;
                  if (!mem_we) data_read <= mem_dout;
                  // A write finishes on its single completion beat
                  if (mem_we || cnt == LAST) begin
                     ba_rdy[win] <= 1'b1;
                     st          <= IDLE;
`ifdef JTCOP_ARB_PRIO0_EN
                     if (win != 2'd0) ptr <= win + 2'd1;
`else
                     ptr <= win + 2'd1;
`endif
                  end else begin
                     cnt <= cnt + 2'd1;
                  end
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtcop_bank_arb.sv
// Bench for jtcop_bank_arb: transaction-level arbitration model plus per-cycle output compare.
// Build with or without JTCOP_ARB_PRIO0_EN; expectations follow the macro.
module tb_jtcop_bank_arb;

   localparam int AW    = 22;
   localparam int BURST = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
   logic [3:0]    ba_rd;
   logic          ba_wr;
   logic [15:0]   ba0_din;
   logic [1:0]    ba0_din_m;
   logic [3:0]    ba_ack, ba_dst, ba_dok, ba_rdy;
   logic [15:0]   data_read;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [15:0]   mem_din;
   logic [1:0]    mem_mask;
   logic          mem_gnt;
   logic          mem_vld;
   logic [15:0]   mem_dout;

   jtcop_bank_arb #(.AW(AW), .BURST(BURST)) dut (
      .clk(clk), .rst(rst),
      .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
      .ba_rd(ba_rd), .ba_wr(ba_wr), .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
      .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_dok(ba_dok), .ba_rdy(ba_rdy),
      .data_read(data_read),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
      .mem_mask(mem_mask), .mem_gnt(mem_gnt), .mem_vld(mem_vld), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // expected outputs, maintained by the transaction model
   logic          exp_req, exp_we;
   logic [AW-1:0] exp_addr;
   logic [15:0]   exp_din, exp_data;
   logic [1:0]    exp_mask;
   logic [3:0]    exp_ack, exp_dst, exp_dok, exp_rdy;
   int            m_ptr;
   int            word_gap;

   // observations used for literal pins
   int            ack_q[$];
   int            req_cycles;
   logic [AW-1:0] cap_addr;
   logic          cap_we;
   logic [15:0]   cap_din, cap_dst_data;
   logic [1:0]    cap_mask;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   always @(negedge clk) begin
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      chk("ba_ack", 32'(ba_ack), 32'(exp_ack));
      chk("ba_dst", 32'(ba_dst), 32'(exp_dst));
      chk("ba_dok", 32'(ba_dok), 32'(exp_dok));
      chk("ba_rdy", 32'(ba_rdy), 32'(exp_rdy));
      chk("data_read", 32'(data_read), 32'(exp_data));
      if (exp_req) begin
         chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
         chk("mem_we", 32'(mem_we), 32'(exp_we));
         if (exp_we) begin
            chk("mem_din", 32'(mem_din), 32'(exp_din));
            chk("mem_mask", 32'(mem_mask), 32'(exp_mask));
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) if (ba_ack[k]) ack_q.push_back(k);
      if (mem_req) begin
         req_cycles++;
         cap_addr = mem_addr;
         cap_we   = mem_we;
         cap_din  = mem_din;
         cap_mask = mem_mask;
      end
      if (ba_dst != 4'd0) cap_dst_data = data_read;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int pick(input logic [3:0] r, input int p);
`ifdef JTCOP_ARB_PRIO0_EN
      if (r[0]) return 0;
      r[0] = 1'b0;
`endif
      for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   function automatic logic [AW-1:0] addr_of(input int w);
      case (w)
         0:       return ba0_addr;
         1:       return ba1_addr;
         2:       return ba2_addr;
         default: return ba3_addr;
      endcase
   endfunction

   task automatic advance(input int w);
`ifdef JTCOP_ARB_PRIO0_EN
      if (w != 0) m_ptr = (w + 1) % 4;
`else
      m_ptr = (w + 1) % 4;
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      exp_ack = '0;
      exp_dst = '0;
      exp_dok = '0;
      exp_rdy = '0;
   endtask

   task automatic drop_req(input int w, input bit wr);
      if (wr) ba_wr = 1'b0;
      else    ba_rd[w] = 1'b0;
   endtask

   task automatic clear_exp();
      exp_req = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_din = '0; exp_mask = '0;
      exp_data = '0; exp_ack = '0; exp_dst = '0; exp_dok = '0; exp_rdy = '0;
      m_ptr = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_exp();
      step();
      step();
      rst = 1'b0;
   endtask

   // One transaction as the memory controller sees it. mode: 0 drop request on ack,
   // 1 drop right after the latch, 2 hold. Stops after nstop read words if nstop < BURST.
   task automatic serve(input int gwait, input int mode, input int nstop, input int stray,
                        input logic [15:0] d0, input logic [15:0] d1, output int w);
      logic [3:0]  r;
      bit          wr;
      logic [15:0] words[4];
      words[0] = d0; words[1] = d1; words[2] = ~d0; words[3] = ~d1;
      r = {ba_rd[3:1], ba_rd[0] | ba_wr};
      w = pick(r, m_ptr);
      if (w < 0) begin
         total++; bad++;
         $display("FAIL serve: no request pending");
         return;
      end
      wr = (w == 0) && ba_wr;
      exp_addr = addr_of(w);
      exp_we   = wr;
      if (wr) begin
         exp_din  = ba0_din;
         exp_mask = ba0_din_m;
      end
      step();
      exp_req = 1'b1;
      if (mode == 1) drop_req(w, wr);
      for (int i = 0; i < gwait; i++) begin
         if (i == stray) begin
            mem_vld  = 1'b1;
            mem_dout = 16'hDEAD;
         end
         step();
         mem_vld = 1'b0;
      end
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      exp_req = 1'b0;
      exp_ack[w] = 1'b1;
      if (mode == 0) drop_req(w, wr);
      if (wr) begin
         step();
         mem_dout = 16'hBEEF;
         mem_vld  = 1'b1;
         step();
         mem_vld = 1'b0;
         exp_dst[w] = 1'b1; exp_dok[w] = 1'b1; exp_rdy[w] = 1'b1;
         advance(w);
         return;
      end
      for (int i = 0; i < BURST; i++) begin
         mem_dout = words[i];
         mem_vld  = 1'b1;
         step();
         mem_vld = 1'b0;
         exp_dok[w] = 1'b1;
         if (i == 0) exp_dst[w] = 1'b1;
         exp_data = words[i];
         if (i == BURST - 1) begin
            exp_rdy[w] = 1'b1;
            advance(w);
         end else if (i + 1 == nstop) begin
            return;
         end else begin
            repeat (word_gap) step();
         end
      end
   endtask

   int w, wa, wb;

   initial begin
      rst = 1'b1;
      ba0_addr = 22'h00_0100; ba1_addr = 22'h01_1111;
      ba2_addr = 22'h02_2222; ba3_addr = 22'h03_3333;
      ba_rd = '0; ba_wr = 1'b0; ba0_din = '0; ba0_din_m = '0;
      mem_gnt = 1'b0; mem_vld = 1'b0; mem_dout = '0;
      word_gap = 0; req_cycles = 0;
      cap_addr = '0; cap_we = 1'b0; cap_din = '0; cap_mask = '0; cap_dst_data = '0;
      do_reset();

      // single bank 2 read burst
      ba2_addr = 22'h10_0040;
      ba_rd = 4'b0100;
      serve(2, 0, BURST, -1, 16'hAAAA, 16'h5555, w);
      chk("t1_winner", 32'(w), 32'd2);
      chk("t1_addr", 32'(cap_addr), 32'h10_0040);
      chk("t1_we", 32'(cap_we), 32'd0);
      chk("t1_dst_data", 32'(cap_dst_data), 32'hAAAA);
      chk("t1_rdy", 32'(ba_rdy), 32'b0100);
      chk("t1_rdy_data", 32'(data_read), 32'h5555);
      chk("t1_acks", 32'(ack_q.size()), 32'd1);
      step();

      // bank 0 write, with a bank 0 read also pending: write goes first
      ba0_addr = 22'h10_2001; ba0_din = 16'h1234; ba0_din_m = 2'b10;
      ba_wr = 1'b1; ba_rd = 4'b0001;
      serve(0, 0, BURST, -1, 16'h0, 16'h0, w);
      chk("t2_we", 32'(cap_we), 32'd1);
      chk("t2_addr", 32'(cap_addr), 32'h10_2001);
      chk("t2_din", 32'(cap_din), 32'h1234);
      chk("t2_mask", 32'(cap_mask), 32'b10);
      chk("t2_pulses", 32'({ba_dst, ba_dok, ba_rdy}), 32'h111);
      chk("t2_data_held", 32'(data_read), 32'h5555);
      serve(1, 0, BURST, -1, 16'h0F0F, 16'hF0F0, w);
      chk("t2_read_after_write", 32'(w), 32'd0);
      step();

      // all four banks requesting continuously from ptr 0
      do_reset();
      ack_q.delete();
      ba_rd = 4'b1111;
      for (int n = 0; n < 5; n++) serve(0, 2, BURST, -1, 16'(16'h1000 + n), 16'(16'h2000 + n), w);
      ba_rd = '0;
      repeat (3) step();
      chk("t3_acks", 32'(ack_q.size()), 32'd5);
      for (int n = 0; n < 5 && n < ack_q.size(); n++) begin
`ifdef JTCOP_ARB_PRIO0_EN
         chk("t3_order", 32'(ack_q[n]), 32'd0);
`else
         chk("t3_order", 32'(ack_q[n]), 32'(n % 4));
`endif
      end

      // reset in DATA after the first word; ptr is 2 beforehand
      ba_rd = 4'b0010;
      serve(0, 0, BURST, -1, 16'h3333, 16'h4444, w);
      step();
      ba_rd = 4'b1000;
      serve(1, 0, 1, -1, 16'h7777, 16'h8888, w);
      rst = 1'b1;
      #1;
      chk("t4_rst_pulses", 32'({ba_ack, ba_dst, ba_dok, ba_rdy}), 32'h0);
      chk("t4_rst_req", 32'(mem_req), 32'd0);
      chk("t4_rst_data", 32'(data_read), 32'd0);
      chk("t4_rst_cmd", 32'({mem_addr, mem_we, mem_mask}), 32'd0);
      chk("t4_rst_din", 32'(mem_din), 32'd0);
      clear_exp();
      ba_rd = 4'b0110;
      step();
      rst = 1'b0;
      serve(0, 0, BURST, -1, 16'h9999, 16'hABCD, wa);
      serve(0, 0, BURST, -1, 16'hCDEF, 16'h0123, wb);
      chk("t4_first_after_rst", 32'(wa), 32'd1);
      chk("t4_second_after_rst", 32'(wb), 32'd2);
      step();

      // bank 3 drops its request right after the latch; grant withheld 10 cycles
      req_cycles = 0;
      ba_rd = 4'b1000;
      serve(10, 1, BURST, 4, 16'h5A5A, 16'hA5A5, w);
      chk("t5_winner", 32'(w), 32'd3);
      chk("t5_req_cycles", 32'(req_cycles), 32'd11);   // 10 wait cycles + the gnt cycle
      chk("t5_rdy", 32'(ba_rdy), 32'b1000);
      step();

      // ptr at 2 with banks 0 and 2 pending
      ba_rd = 4'b0010;
      serve(0, 0, BURST, -1, 16'h1111, 16'h2222, w);
      step();
      word_gap = 1;
      ba_rd = 4'b0101;
      serve(1, 0, BURST, -1, 16'h6666, 16'h7777, wa);
      serve(1, 0, BURST, -1, 16'h8888, 16'h9999, wb);
`ifdef JTCOP_ARB_PRIO0_EN
      chk("t6_first", 32'(wa), 32'd0);
      chk("t6_second", 32'(wb), 32'd2);
`else
      chk("t6_first", 32'(wa), 32'd2);
      chk("t6_second", 32'(wb), 32'd0);
`endif
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
